// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter slice:
// register address width, default data width, the x0 address, the arbiter
// state encoding and a small helper that tells whether a destination
// actually writes the register file.
package regfile_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int XLEN_DEFAULT = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_e;

  // x0 is hardwired to zero, so a write to it is a no-op at the register file.
  function automatic logic rd_writes(input logic [REG_ADDR_W-1:0] rd);
    return rd != REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters (pipeline WB stage on port 0,
// long-latency unit on port 1), the arbiter and the register-file write port.
//   p0_valid/p0_rd/p0_data, p1_valid/p1_rd/p1_data : requests (master drives)
//   p0_ready/p1_ready, p0_stall                      : grants (slave drives)
//   rf_write_enable/rf_write_reg/rf_write_data       : registered RF write
//   grant_src                                        : source of current RF write
// master = requester side, slave = arbiter.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);
  logic                  p0_valid;
  logic                  p0_ready;
  logic [REG_ADDR_W-1:0] p0_rd;
  logic [XLEN-1:0]       p0_data;
  logic                  p1_valid;
  logic                  p1_ready;
  logic [REG_ADDR_W-1:0] p1_rd;
  logic [XLEN-1:0]       p1_data;
  logic                  p0_stall;
  logic                  rf_write_enable;
  logic [REG_ADDR_W-1:0] rf_write_reg;
  logic [XLEN-1:0]       rf_write_data;
  logic                  grant_src;

  modport master (
    output p0_valid, p0_rd, p0_data, p1_valid, p1_rd, p1_data,
    input  p0_ready, p1_ready, p0_stall,
    input  rf_write_enable, rf_write_reg, rf_write_data, grant_src
  );

  modport slave (
    input  p0_valid, p0_rd, p0_data, p1_valid, p1_rd, p1_data,
    output p0_ready, p1_ready, p0_stall,
    output rf_write_enable, rf_write_reg, rf_write_data, grant_src
  );
endinterface

// File: rtl/regfile_wb_arbiter_bypass_mux.sv
// wb_bypass_mux: per-read-port forwarding of the registered writeback that the
// register file has not captured yet. Only exists when WB_BYPASS_EN is defined.
//   rs, rf_rdata                 : read address and raw register-file data
//   wr_en, wr_reg, wr_data       : registered write heading into the RF
//   byp_data                     : forwarded read data (combinational)
`ifdef WB_BYPASS_EN
module wb_bypass_mux
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [XLEN-1:0]       rf_rdata,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_reg,
  input  logic [XLEN-1:0]       wr_data,
  output logic [XLEN-1:0]       byp_data
);
  assign byp_data = (wr_en && wr_reg == rs && rd_writes(rs)) ? wr_data : rf_rdata;
endmodule
`endif

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port between the
// in-order WB stage (port 0, fixed priority) and a long-latency unit (port 1).
// Port 1 is forced through for one grant after waiting STARVE_LIMIT cycles.
// The winning write is registered for one cycle before reaching the RF.
//   clk, reset : clock, synchronous active-high reset
//   bus        : regfile_wb_arbiter_if.slave (requests, grants, RF write)
// WB_BYPASS_EN adds rs_a/rs_b, rf_rdata_a/b inputs and byp_data_a/b outputs
// that forward the registered write to two read ports.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = XLEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_wb_arbiter_if.slave   bus
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] rs_a,
  input  logic [REG_ADDR_W-1:0] rs_b,
  input  logic [XLEN-1:0]       rf_rdata_a,
  input  logic [XLEN-1:0]       rf_rdata_b,
  output logic [XLEN-1:0]       byp_data_a,
  output logic [XLEN-1:0]       byp_data_b
`endif
);
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  arb_state_e            state;
  logic [WAIT_W-1:0]     wait_cnt, wait_nxt;
  logic                  p0_rdy, p1_rdy, p0_xfer, p1_xfer;
  logic                  we_q, src_q;
  logic [REG_ADDR_W-1:0] reg_q;
  logic [XLEN-1:0]       data_q;

  // Grants depend only on valid and state, never on rd/data.
  always_comb begin
    if (state == ARB_FORCE) begin
      p0_rdy = 1'b0;
      p1_rdy = bus.p1_valid;
    end else begin
      p0_rdy = bus.p0_valid;
      p1_rdy = bus.p1_valid && !bus.p0_valid;
    end
  end

  assign p0_xfer = bus.p0_valid && p0_rdy;
  assign p1_xfer = bus.p1_valid && p1_rdy;

  // Count of cycles port 1 has been left waiting, including this one.
  always_comb begin
    wait_nxt = wait_cnt;
    if (!bus.p1_valid || p1_xfer) wait_nxt = '0;
    else if (wait_cnt != WAIT_MAX) wait_nxt = wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_NORMAL;
      wait_cnt <= '0;
      we_q     <= 1'b0;
      reg_q    <= '0;
      data_q   <= '0;
      src_q    <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      we_q     <= 1'b0;
      // x0 transfers complete the handshake but never strobe the RF.
      if (p0_xfer) begin
        we_q   <= rd_writes(bus.p0_rd);
        reg_q  <= bus.p0_rd;
        data_q <= bus.p0_data;
        src_q  <= 1'b0;
      end else if (p1_xfer) begin
        we_q   <= rd_writes(bus.p1_rd);
        reg_q  <= bus.p1_rd;
        data_q <= bus.p1_data;
        src_q  <= 1'b1;
      end
      case (state)
        // Enter FORCE on the edge that completes the STARVE_LIMIT-th waiting
        // cycle, so port 1 is granted in the very next cycle.
        ARB_NORMAL: if (wait_nxt == WAIT_MAX) state <= ARB_FORCE;
        // One grant only; a dropped request also releases FORCE.
        ARB_FORCE:  if (p1_xfer || !bus.p1_valid) state <= ARB_NORMAL;
        default:    state <= ARB_NORMAL;
      endcase
    end
  end

  assign bus.p0_ready        = p0_rdy;
  assign bus.p1_ready        = p1_rdy;
  assign bus.p0_stall        = bus.p0_valid && !p0_rdy;
  assign bus.rf_write_enable = we_q;
  assign bus.rf_write_reg    = reg_q;
  assign bus.rf_write_data   = data_q;
  assign bus.grant_src       = src_q;

`ifdef WB_BYPASS_EN
  logic [1:0][REG_ADDR_W-1:0] rs;
  logic [1:0][XLEN-1:0]       rdata, byp;

  assign rs    = {rs_b, rs_a};
  assign rdata = {rf_rdata_b, rf_rdata_a};

  for (genvar g = 0; g < 2; g++) begin : g_byp
    wb_bypass_mux #(.XLEN(XLEN)) u_mux (
      .rs       (rs[g]),
      .rf_rdata (rdata[g]),
      .wr_en    (we_q),
      .wr_reg   (reg_q),
      .wr_data  (data_q),
      .byp_data (byp[g])
    );
  end

  assign byp_data_a = byp[0];
  assign byp_data_b = byp[1];
`endif

endmodule
